shift_seq_ctrl: RTL and testbench
=================================

# shift_seq_ctrl

Sequencing controller for the 8-bit shift register datapath: it serves two requesters, grants one at a time with round-robin arbitration, and executes each command on an internal 8-bit register. Command encoding is the datapath's own 3-bit op code: NOP, LOAD, LSL, LSR, ASR. A shift of 0–7 bits is split into per-cycle steps of at most 3 bits, which is the datapath's 2-bit shamt limit. The block sits between command sources and the result consumer, and owns the shared shift register.

## Interface
- No parameters; data width fixed at 8, op width 3, amount width 3.
- clk  input  1  single clock, all state updates on rising edge
- reset  input  1  synchronous, active-high; clears all state
- a_valid  input  1  requester A command valid
- a_ready  output  1  requester A command accepted this cycle when high with a_valid
- a_op  input  3  000 NOP, 001 LOAD, 010 LSL, 011 LSR, 100 ASR, 101–111 see Configuration
- a_amt  input  3  total shift amount 0–7; ignored for NOP/LOAD
- a_data  input  8  load value; ignored for non-LOAD ops
- b_valid, b_ready, b_op, b_amt, b_data  same as A, requester B
- busy  output  1  high in EXEC and DONE
- done  output  1  one-cycle completion pulse
- done_id  output  1  0 = A, 1 = B; valid while done
- result  output  8  register value; always driven, final value while done

## Operation
- States: IDLE, EXEC, DONE. Reset values: state IDLE, register 0x00, done 0, done_id 0, busy 0, result 0x00, RR pointer favours A.
- Arbitration happens in IDLE only:
  - If only one requester is valid, it is granted.
  - If both are valid, grant the one not served last. After reset, A wins a tie.
  - x_ready = (state==IDLE) & granted(x). Both readies are never high together.
  - The pointer updates only on an accepted transfer.
- Accept (valid & ready): latch op, amt, data, id; go to EXEC. A valid request must hold its op, amt and data until accepted.
- EXEC, one step per cycle, with step = min(rem,3):
  - LSL: reg <= reg << step, zero fill.
  - LSR: reg <= reg >> step, zero fill.
  - ASR: reg <= arithmetic shift right by step, bit 7 replicated.
  - rem <= rem - step.
- LOAD (reg <= data), NOP, and any shift with amt 0 take exactly one EXEC cycle. NOP and amt 0 leave reg unchanged.
- Leave EXEC for DONE when rem - step == 0 at the stepping edge.
- DONE: done=1 for exactly one cycle; done_id = latched id; next state IDLE.
- Register contents persist across commands. Shifts operate on the previous result.

## Timing
- EXEC cycles k = max(1, ceil(amt/3)) for shifts; k = 1 for LOAD and NOP.
  - Examples: amt 0–3 gives 1, amt 4–6 gives 2, amt 7 gives 3 (steps 3,3,1).
- Timeline for a command accepted at edge T:
  - EXEC occupies cycles after T, T+1 … T+k-1.
  - done is high in the cycle after edge T+k.
  - IDLE (ready possible again) after edge T+k+1.
- Throughput: one command per k+2 cycles; no overlap, no back-to-back acceptance.
- Outputs are registered except a_ready/b_ready, which are combinational from state, pointer and valids.
- Reset asserted at any edge, including mid-EXEC or during DONE: the in-flight command is discarded, no done pulse, register cleared. Ready may assert in the first cycle after reset deasserts.
- A valid dropped before acceptance is simply not served; it does not move the pointer.

## Configuration
- SHIFT_SEQ_ROR_EN defined:
  - op 101 = rotate right by amt (0–7), executed in ≤3-bit steps like the other shifts.
  - 110/111 execute as NOP.
- SHIFT_SEQ_ROR_EN undefined: 101–111 all execute as NOP (one EXEC cycle, reg unchanged, done still pulses).

## Test plan
- A LOAD 0xB5 → done 2 cycles after accept edge, result 0xB5, done_id 0.
- Then A LSL amt 5 → 2 EXEC cycles (0xA8 after step 1), done with result 0xA0.
- LOAD 0x80, then ASR amt 7 → 3 EXEC cycles, result 0xFF. LOAD 0xF0, then LSR amt 4 → result 0x0F.
- A and B both valid in the first cycle after reset (A LOAD 0x11, B LOAD 0x3C):
  - A is granted first → done_id 0, result 0x11.
  - B is granted next → done_id 1, result 0x3C.
  - A re-requests alongside a new B request → B is not starved; the grant goes to A only after B has been served.
- Reset asserted mid-EXEC of ASR amt 7 → no done pulse, result 0x00, a_ready high in the first cycle after reset release.
- LOAD 0x01, then op 101 amt 1 → result 0x80 with SHIFT_SEQ_ROR_EN, 0x01 without.

Source files
------------

// File: rtl/shift_seq_ctrl.sv
// -----------------------------------------------------------------------------
// shift_seq_ctrl
//
// Sequencing controller for the shared 8-bit shift register. Two requesters (A
// and B) issue commands; one command is accepted at a time using round-robin
// arbitration. Each command is executed on the internal register. A shift of
// 0-7 bits is split into steps of at most 3 bits, one step per cycle.
//
// Op codes: 000 NOP, 001 LOAD, 010 LSL, 011 LSR, 100 ASR.
// Optional feature macro: SHIFT_SEQ_ROR_EN
//   defined   : 101 = rotate right by amt (stepped like other shifts),
//               110/111 = NOP
//   undefined : 101-111 = NOP
//
// Ports
//   clk                 clock, all state updates on the rising edge
//   reset               synchronous active-high reset, clears all state
//   a_valid / b_valid   command valid from requester A / B
//   a_ready / b_ready   command accepted this cycle (combinational)
//   a_op / b_op         3-bit op code
//   a_amt / b_amt       total shift amount 0-7
//   a_data / b_data     LOAD value
//   busy                high while a command is executing or completing
//   done                one-cycle completion pulse
//   done_id             0 = A, 1 = B; valid while done
//   result              current register value, final value while done
// -----------------------------------------------------------------------------
module shift_seq_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic       a_valid,
  output logic       a_ready,
  input  logic [2:0] a_op,
  input  logic [2:0] a_amt,
  input  logic [7:0] a_data,
  input  logic       b_valid,
  output logic       b_ready,
  input  logic [2:0] b_op,
  input  logic [2:0] b_amt,
  input  logic [7:0] b_data,
  output logic       busy,
  output logic       done,
  output logic       done_id,
  output logic [7:0] result
);

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_LOAD = 3'd1;
  localparam logic [2:0] OP_LSL  = 3'd2;
  localparam logic [2:0] OP_LSR  = 3'd3;
  localparam logic [2:0] OP_ASR  = 3'd4;
`ifdef SHIFT_SEQ_ROR_EN
  localparam logic [2:0] OP_ROR  = 3'd5;
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------

  // Ops that consume the amount field; everything else runs a single
  // zero-amount step.
  function automatic logic is_shift_op(input logic [2:0] op);
    logic r;
    case (op)
      OP_LSL:  r = 1'b1;
      OP_LSR:  r = 1'b1;
      OP_ASR:  r = 1'b1;
`ifdef SHIFT_SEQ_ROR_EN
      OP_ROR:  r = 1'b1;
`endif
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // Per-cycle step: the datapath can shift at most 3 bits at once.
  function automatic logic [1:0] step_of(input logic [2:0] rem);
    logic [1:0] r;
    if (rem >= 3'd3) begin
      r = 2'd3;
    end else begin
      r = rem[1:0];
    end
    return r;
  endfunction

  // One datapath step. A zero step leaves the value untouched for all shifts.
  function automatic logic [7:0] apply_step(input logic [2:0] op,
                                            input logic [7:0] val,
                                            input logic [1:0] step,
                                            input logic [7:0] ld);
    logic [7:0]  r;
    logic [15:0] dbl;
    // Rotate is a logical shift of the value concatenated with itself.
    dbl = {val, val} >> step;
    case (op)
      OP_NOP:  r = val;
      OP_LOAD: r = ld;
      OP_LSL:  r = val << step;
      OP_LSR:  r = val >> step;
      OP_ASR:  r = 8'($signed(val) >>> step);
`ifdef SHIFT_SEQ_ROR_EN
      OP_ROR:  r = dbl[7:0];
`endif
      default: r = val;
    endcase
`ifndef SHIFT_SEQ_ROR_EN
    // Without rotate support the doubled word is not needed.
    r = r | (dbl[15:8] & 8'h00);
`endif
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t     state_r;
  state_t     state_nxt_s;
  logic       prio_b_r;      // 1: B wins a tie (A was served last)
  logic [2:0] op_r;
  logic [2:0] rem_r;         // bits still to shift
  logic [7:0] data_r;
  logic       id_r;
  logic [7:0] shreg_r;
  logic       done_r;
  logic       done_id_r;
  logic       busy_r;

  logic       grant_a_s;
  logic       grant_b_s;
  logic       accept_s;
  logic [1:0] step_s;
  logic [2:0] rem_nxt_s;
  logic [7:0] shreg_nxt_s;
  logic       last_step_s;
  logic [2:0] acc_op_s;
  logic [2:0] acc_amt_s;
  logic [7:0] acc_data_s;

  // Round-robin grant; only meaningful while idle (ready gates on state).
  always_comb begin
    grant_a_s = 1'b0;
    grant_b_s = 1'b0;
    if (a_valid && b_valid) begin
      grant_a_s = ~prio_b_r;
      grant_b_s = prio_b_r;
    end else begin
      grant_a_s = a_valid;
      grant_b_s = b_valid;
    end
  end

  assign a_ready  = (state_r == ST_IDLE) & grant_a_s;
  assign b_ready  = (state_r == ST_IDLE) & grant_b_s;
  // Ready is only ever raised together with its valid.
  assign accept_s = a_ready | b_ready;

  // Select the fields of the requester being accepted.
  always_comb begin
    acc_op_s   = 3'd0;
    acc_amt_s  = 3'd0;
    acc_data_s = 8'h00;
    if (b_ready) begin
      acc_op_s   = b_op;
      acc_amt_s  = b_amt;
      acc_data_s = b_data;
    end else begin
      acc_op_s   = a_op;
      acc_amt_s  = a_amt;
      acc_data_s = a_data;
    end
  end

  // Step computation and next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    step_s      = step_of(rem_r);
    rem_nxt_s   = rem_r - {1'b0, step_s};
    last_step_s = (rem_nxt_s == 3'd0);
    shreg_nxt_s = apply_step(op_r, shreg_r, step_s, data_r);
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_nxt_s = ST_EXEC;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_EXEC: begin
        if (last_step_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_EXEC;
        end
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Arbitration pointer: moves only when a transfer is accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      prio_b_r <= 1'b0;
    end else if (accept_s) begin
      prio_b_r <= a_ready;
    end else begin
      prio_b_r <= prio_b_r;
    end
  end

  // Command latch and remaining-amount counter. Non-shift ops start with
  // nothing to shift so they finish after one EXEC cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_r   <= 3'd0;
      rem_r  <= 3'd0;
      data_r <= 8'h00;
      id_r   <= 1'b0;
    end else if (accept_s) begin
      op_r   <= acc_op_s;
      rem_r  <= is_shift_op(acc_op_s) ? acc_amt_s : 3'd0;
      data_r <= acc_data_s;
      id_r   <= b_ready;
    end else if (state_r == ST_EXEC) begin
      rem_r  <= rem_nxt_s;
    end else begin
      rem_r  <= rem_r;
    end
  end

  // Shared shift register; contents persist between commands.
  always_ff @(posedge clk) begin
    if (reset) begin
      shreg_r <= 8'h00;
    end else if (state_r == ST_EXEC) begin
      shreg_r <= shreg_nxt_s;
    end else begin
      shreg_r <= shreg_r;
    end
  end

  // Registered status outputs; done coincides with the DONE state.
  always_ff @(posedge clk) begin
    if (reset) begin
      done_r    <= 1'b0;
      done_id_r <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      done_r    <= (state_r == ST_EXEC) && last_step_s;
      busy_r    <= (state_nxt_s != ST_IDLE);
      if ((state_r == ST_EXEC) && last_step_s) begin
        done_id_r <= id_r;
      end else begin
        done_id_r <= done_id_r;
      end
    end
  end

  assign busy    = busy_r;
  assign done    = done_r;
  assign done_id = done_id_r;
  assign result  = shreg_r;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
module tb_shift_seq_ctrl;

  logic       clk;
  logic       reset;
  logic       a_valid, b_valid;
  logic       a_ready, b_ready;
  logic [2:0] a_op, a_amt, b_op, b_amt;
  logic [7:0] a_data, b_data;
  logic       busy, done, done_id;
  logic [7:0] result;

  shift_seq_ctrl dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_op(a_op), .a_amt(a_amt), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_op(b_op), .b_amt(b_amt), .b_data(b_data),
    .busy(busy), .done(done), .done_id(done_id), .result(result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [2:0] op; logic [2:0] amt; logic [7:0] data; } cmd_t;
  typedef struct { logic id; logic [7:0] res; int dcyc; } exp_t;

  cmd_t a_q[$];
  cmd_t b_q[$];
  exp_t sb_q[$];
  logic done_hist[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_a = 0;
  int acc_b = 0;
  bit rand_mode = 1'b0;

  // reference model state
  logic [7:0] mreg = 8'h00;
  logic       mprio_b = 1'b0;
  int         busy_until = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit ref_is_shift(input logic [2:0] op);
    bit r;
    r = (op == 3'd2) || (op == 3'd3) || (op == 3'd4);
`ifdef SHIFT_SEQ_ROR_EN
    r = r || (op == 3'd5);
`endif
    return r;
  endfunction

  // Whole-command result computed arithmetically from the full amount.
  function automatic logic [7:0] ref_exec(input logic [2:0] op, input int amt,
                                          input logic [7:0] data, input logic [7:0] cur);
    int v, p, s;
    logic [7:0] r;
    v = int'(cur);
    p = 1 << amt;
    r = cur;
    case (op)
      3'd1: r = data;
      3'd2: r = 8'((v * p) % 256);
      3'd3: r = 8'(v / p);
      3'd4: begin
        s = (v >= 128) ? v - 256 : v;
        if (s < 0) s = -((-s + p - 1) / p);
        else       s = s / p;
        r = 8'(s & 255);
      end
`ifdef SHIFT_SEQ_ROR_EN
      3'd5: r = 8'((v / p) + (v % p) * (256 / p));
`endif
      default: r = cur;
    endcase
    return r;
  endfunction

  function automatic int ref_cycles(input logic [2:0] op, input int amt);
    if (ref_is_shift(op) && amt > 0) return (amt + 2) / 3;
    return 1;
  endfunction

  // cycle counter: number of rising edges so far
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Reference model + scoreboard monitor, evaluated mid-cycle.
  initial forever begin
    @(negedge clk);
    if (reset) begin
      sb_q.delete();
      mreg = 8'h00;
      mprio_b = 1'b0;
      busy_until = 0;
    end else begin
      bit idle, ega, egb;
      if (done) begin
        if (sb_q.size() == 0) begin
          chk("spurious_done", 32'(done), 32'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("done_id", 32'(done_id), 32'(e.id));
          chk("done_result", 32'(result), 32'(e.res));
          chk("done_cycle", 32'(cyc), 32'(e.dcyc));
          done_hist.push_back(done_id);
        end
      end else if (sb_q.size() > 0 && cyc > sb_q[0].dcyc) begin
        chk("missing_done", 32'(done), 32'd1);
        sb_q.delete(0);
      end
      chk("busy", 32'(busy), 32'(cyc < busy_until));
      idle = (cyc >= busy_until);
      ega = idle && a_valid && (!b_valid || !mprio_b);
      egb = idle && b_valid && (!a_valid || mprio_b);
      chk("a_ready", 32'(a_ready), 32'(ega));
      chk("b_ready", 32'(b_ready), 32'(egb));
      if (ega || egb) begin
        logic [2:0] op;
        int amt, t, k;
        exp_t e;
        op  = ega ? a_op : b_op;
        amt = int'(ega ? a_amt : b_amt);
        mreg = ref_exec(op, amt, ega ? a_data : b_data, mreg);
        k = ref_cycles(op, amt);
        t = cyc + 1;
        e.id = egb;
        e.res = mreg;
        e.dcyc = t + k;
        sb_q.push_back(e);
        busy_until = t + k + 1;
        mprio_b = ega;
        if (ega) acc_a++;
        else     acc_b++;
      end
    end
  end

  // Requester drivers: present queued commands, hold until accepted.
  initial begin
    int seen_a, seen_b;
    seen_a = 0;
    seen_b = 0;
    a_valid = 1'b0; a_op = 3'd0; a_amt = 3'd0; a_data = 8'h00;
    b_valid = 1'b0; b_op = 3'd0; b_amt = 3'd0; b_data = 8'h00;
    forever begin
      @(posedge clk);
      #2;
      if (a_valid && acc_a != seen_a) begin
        seen_a = acc_a;
        if (a_q.size() > 0) a_q.delete(0);
        a_valid = 1'b0;
      end else if (a_valid && rand_mode && $urandom_range(0, 15) == 0) begin
        a_valid = 1'b0;
      end
      if (reset) a_valid = 1'b0;
      else if (!a_valid && a_q.size() > 0 && (!rand_mode || $urandom_range(0, 2) != 0)) begin
        a_op = a_q[0].op; a_amt = a_q[0].amt; a_data = a_q[0].data; a_valid = 1'b1;
      end
      if (b_valid && acc_b != seen_b) begin
        seen_b = acc_b;
        if (b_q.size() > 0) b_q.delete(0);
        b_valid = 1'b0;
      end else if (b_valid && rand_mode && $urandom_range(0, 15) == 0) begin
        b_valid = 1'b0;
      end
      if (reset) b_valid = 1'b0;
      else if (!b_valid && b_q.size() > 0 && (!rand_mode || $urandom_range(0, 2) != 0)) begin
        b_op = b_q[0].op; b_amt = b_q[0].amt; b_data = b_q[0].data; b_valid = 1'b1;
      end
    end
  end

  task automatic push_a(input logic [2:0] op, input logic [2:0] amt, input logic [7:0] data);
    cmd_t c;
    c.op = op; c.amt = amt; c.data = data;
    a_q.push_back(c);
  endtask

  task automatic push_b(input logic [2:0] op, input logic [2:0] amt, input logic [7:0] data);
    cmd_t c;
    c.op = op; c.amt = amt; c.data = data;
    b_q.push_back(c);
  endtask

  task automatic wait_drain(input int limit);
    int n;
    n = 0;
    while ((a_q.size() > 0 || b_q.size() > 0 || sb_q.size() > 0 || busy) && n < limit) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= limit) chk("drain_timeout", 32'(n), 32'(limit - 1));
  endtask

  // Returns just before the edge that accepts the pending A command.
  task automatic wait_acc_a(input int old);
    int n;
    n = 0;
    while (acc_a == old && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (acc_a == old) chk("accept_timeout", 32'(acc_a), 32'(old + 1));
  endtask

  initial begin
    int old;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // reset state
    @(negedge clk);
    chk("rst_result", 32'(result), 32'h00);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_done_id", 32'(done_id), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_a_ready", 32'(a_ready), 32'd0);

    // LOAD then LSL 5 with intermediate step value
    @(posedge clk); #1;
    push_a(3'd1, 3'd0, 8'hB5);
    wait_drain(100);
    chk("load_b5", 32'(result), 32'hB5);
    old = acc_a;
    push_a(3'd2, 3'd5, 8'h00);
    wait_acc_a(old);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("lsl_step1", 32'(result), 32'hA8);
    wait_drain(100);
    chk("lsl5", 32'(result), 32'hA0);

    push_a(3'd1, 3'd0, 8'h80);
    push_a(3'd4, 3'd7, 8'h00);
    wait_drain(100);
    chk("asr7", 32'(result), 32'hFF);
    push_a(3'd1, 3'd0, 8'hF0);
    push_a(3'd3, 3'd4, 8'h00);
    wait_drain(100);
    chk("lsr4", 32'(result), 32'h0F);

    // both valid in the first cycle after reset; round-robin order
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;
    push_a(3'd1, 3'd0, 8'h11);
    push_a(3'd1, 3'd0, 8'h55);
    push_b(3'd1, 3'd0, 8'h3C);
    push_b(3'd1, 3'd0, 8'h77);
    done_hist.delete();
    reset = 1'b0;
    wait_drain(200);
    chk("rr_count", 32'(done_hist.size()), 32'd4);
    if (done_hist.size() == 4) begin
      chk("rr_0", 32'(done_hist[0]), 32'd0);
      chk("rr_1", 32'(done_hist[1]), 32'd1);
      chk("rr_2", 32'(done_hist[2]), 32'd0);
      chk("rr_3", 32'(done_hist[3]), 32'd1);
    end
    chk("rr_final", 32'(result), 32'h77);

    // reset in the middle of ASR 7
    push_a(3'd1, 3'd0, 8'h80);
    wait_drain(100);
    old = acc_a;
    push_a(3'd4, 3'd7, 8'h00);
    wait_acc_a(old);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    push_a(3'd1, 3'd0, 8'h42);
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_a_ready", 32'(a_ready), 32'd1);
    chk("midrst_result", 32'(result), 32'h00);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    wait_drain(100);
    chk("post_rst_load", 32'(result), 32'h42);

    // op 101
    push_a(3'd1, 3'd0, 8'h01);
    push_a(3'd5, 3'd1, 8'h00);
    wait_drain(100);
`ifdef SHIFT_SEQ_ROR_EN
    chk("op101", 32'(result), 32'h80);
`else
    chk("op101", 32'(result), 32'h01);
`endif

    // randomized traffic from both requesters
    rand_mode = 1'b1;
    for (int i = 0; i < 60; i++) begin
      int n;
      n = $urandom_range(0, 3);
      for (int j = 0; j < n; j++) begin
        if ($urandom_range(0, 1) == 0)
          push_a(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
        else
          push_b(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
      end
      repeat ($urandom_range(1, 12)) @(posedge clk);
    end
    wait_drain(5000);
    rand_mode = 1'b0;

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
